// File: rtl/trig_capture_reader.sv
// Circular pre/post-trigger capture ring with an in-order valid/ready replay port.
// The ring is a single-write, single-read block RAM; the replay window starts PRE_TRIG samples before the trigger.
module trig_capture_reader #(
    parameter int WIDTH    = 12,
    parameter int ADDR_W   = 10,
    parameter int PRE_TRIG = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    input  logic             trig,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             busy,
    output logic             triggered
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   PRE_CNT   = (ADDR_W+1)'(PRE_TRIG);
    localparam logic [ADDR_W:0]   POST_CNT  = (ADDR_W+1)'(DEPTH - PRE_TRIG);
    localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PRE_ADDR  = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_READ} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   fill_cnt_q, fill_cnt_d;
    logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic              rd_go_q, rd_go_d;
    logic              dout_valid_q, dout_valid_d;
    logic              dout_last_q, dout_last_d;
    logic [WIDTH-1:0]  dout_q;
    logic              we, rd_en, xfer;

    logic [WIDTH-1:0]  mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= sample_in;
    end

    // The RAM read register doubles as the output register, so a stall simply withholds rd_en.
    always_ff @(posedge clk) begin
        if (rst)        dout_q <= '0;
        else if (rd_en) dout_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            trig_addr_q  <= '0;
            rd_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            rd_go_q      <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            trig_addr_q  <= trig_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            post_cnt_q   <= post_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_go_q      <= rd_go_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        trig_addr_d  = trig_addr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        post_cnt_d   = post_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        rd_go_d      = rd_go_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        we           = 1'b0;
        rd_en        = 1'b0;
        xfer         = dout_valid_q && dout_ready;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    wr_ptr_d   = '0;
                    fill_cnt_d = '0;
                    state_d    = (PRE_TRIG == 0) ? S_ARMED : S_FILL;
                end
            end
            S_FILL: begin
                if (sample_valid) begin
                    we         = 1'b1;
                    wr_ptr_d   = wr_ptr_q + PTR_ONE;
                    fill_cnt_d = fill_cnt_q + CNT_ONE;
                    if (fill_cnt_d == PRE_CNT) state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (sample_valid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (trig) begin
                        trig_addr_d = wr_ptr_q;
                        post_cnt_d  = CNT_ONE;
                        state_d     = (POST_CNT == CNT_ONE) ? S_READ : S_POST;
                    end
                end
            end
            S_POST: begin
                if (sample_valid) begin
                    we         = 1'b1;
                    wr_ptr_d   = wr_ptr_q + PTR_ONE;
                    post_cnt_d = post_cnt_q + CNT_ONE;
                    if (post_cnt_d == POST_CNT) state_d = S_READ;
                end
            end
            S_READ: begin
                if (!rd_go_q) begin
                    rd_go_d  = 1'b1;
                    rd_ptr_d = trig_addr_q - PRE_ADDR;
                    rd_cnt_d = '0;
                end else if (xfer && dout_last_q) begin
                    state_d      = S_IDLE;
                    rd_go_d      = 1'b0;
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                end else if (!dout_valid_q || dout_ready) begin
                    if (rd_cnt_q != DEPTH_CNT) begin
                        rd_en        = 1'b1;
                        rd_ptr_d     = rd_ptr_q + PTR_ONE;
                        rd_cnt_d     = rd_cnt_q + CNT_ONE;
                        dout_valid_d = 1'b1;
                        dout_last_d  = (rd_cnt_q == LAST_IDX);
                    end else begin
                        dout_valid_d = 1'b0;
                        dout_last_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d      = S_IDLE;
            wr_ptr_d     = '0;
            trig_addr_d  = '0;
            rd_ptr_d     = '0;
            fill_cnt_d   = '0;
            post_cnt_d   = '0;
            rd_cnt_d     = '0;
            rd_go_d      = 1'b0;
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            we           = 1'b0;
            rd_en        = 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign busy       = (state_q != S_IDLE);
    assign triggered  = (state_q == S_POST) || (state_q == S_READ);

endmodule

// File: doc/trig_capture_reader.md
# trig_capture_reader

Circular sample capture buffer with pre-trigger depth and a streaming readout port, for the oscilloscope acquisition path. Samples are written continuously into a RAM ring while armed. A trigger freezes the ring after a fixed number of post-trigger samples. The frozen window, from PRE_TRIG samples before the trigger through the end, is then replayed in order to the display/render side over a valid/ready stream. This block is the read end for sample data that the front end delays and aligns.

## Interface
- WIDTH, 12: sample bit width.
- ADDR_W, 10: ring address width; DEPTH = 2**ADDR_W samples.
- PRE_TRIG, 256: samples kept before the trigger sample; legal range 0..DEPTH-1.

- clk  input  1  posedge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- arm  input  1  start a capture; accepted only in IDLE.
- abort  input  1  return to IDLE from any state.
- sample_in  input  WIDTH  acquisition sample.
- sample_valid  input  1  sample_in valid this cycle.
- trig  input  1  trigger qualifier; effective only when sample_valid is also high.
- dout  output  WIDTH  replayed sample.
- dout_valid  output  1  dout valid.
- dout_ready  input  1  consumer accepts dout.
- dout_last  output  1  high with the DEPTH-th (final) replayed sample.
- busy  output  1  state != IDLE.
- triggered  output  1  high in POST and READ.

## Operation
- States: IDLE, FILL, ARMED, POST, READ.
- IDLE → FILL on arm; clears wr_ptr and fill_cnt. If PRE_TRIG == 0, goes directly to ARMED.
- FILL: each sample_valid writes RAM[wr_ptr], then wr_ptr++ (mod DEPTH) and fill_cnt++. When fill_cnt reaches PRE_TRIG → ARMED. trig is ignored in FILL.
- ARMED: sample_valid keeps writing and wraps freely. If a cycle has sample_valid && trig:
  - That cycle's sample is the trigger sample.
  - trig_addr = wr_ptr of that write.
  - post_cnt = 1.
  - Next state is POST.
- POST: each sample_valid writes and post_cnt++. The write that makes post_cnt == DEPTH-PRE_TRIG is the final write (edge E) → READ. trig is ignored.
- PRE_TRIG == DEPTH-1: the trigger sample is the final write, so ARMED goes directly to READ.
- READ:
  - Start address rd_ptr = (trig_addr - PRE_TRIG) mod DEPTH, in ADDR_W-bit wraparound arithmetic.
  - Replays exactly DEPTH samples in write order: RAM[rd_ptr], RAM[rd_ptr+1], … mod DEPTH.
  - No writes occur in READ; sample_valid is ignored.
- Stream rules:
  - Transfer occurs when dout_valid && dout_ready.
  - While dout_valid && !dout_ready, dout and dout_last hold stable and the read does not advance.
  - No samples are dropped or duplicated.
  - dout_valid may stay high back-to-back for full throughput, one sample per clk.
- dout_last is high only with replayed sample index DEPTH-1.
- The transfer of the last sample → IDLE; dout_valid is low the following cycle.
- abort: any state → IDLE on the next edge. dout_valid and dout_last are low after that edge. Pointers and counters are cleared.
- Priority: rst > abort > arm. In READ, abort wins over an in-progress transfer.
- arm outside IDLE is ignored.
- RAM is single write port, single read port, synchronous read with 1-cycle latency, inferred block RAM. RAM contents are not reset.

## Timing
- Reset values: dout=0, dout_valid=0, dout_last=0, busy=0, triggered=0, state=IDLE.
- Write latency: a sample is stored at the edge where sample_valid is sampled high.
- busy rises on the edge after arm is sampled in IDLE.
- triggered rises on the edge that samples the qualified trigger.
- Read latency: the state becomes READ at edge E. The first dout_valid is high after edge E+2.
- Throughput in READ with dout_ready held high: DEPTH consecutive valid cycles; dout_last on the final one.
- After a stall releases, the next transfer happens in the same cycle dout_ready rises, with the held data.
- Minimum arm-to-trigger distance: PRE_TRIG valid samples.

## Test plan
1. Basic window: ADDR_W=4, PRE_TRIG=4. Arm, ramp sample_in 0,1,2… every cycle, trig with the sample whose value is 20. Required: dout = 16..31, 16 transfers, dout_last only with 31, busy low after.
2. Early trigger: same config. Pulse trig with sample 2, during FILL, then with sample 10. Required: the first pulse is ignored; replay is 6..21.
3. Backpressure: dout_ready pseudo-random at roughly 50%. Required: the sequence is identical to scenario 1, and dout is stable during every stall.
4. Wrap-around: trigger lands on wr_ptr 2. Required: replay starts at RAM address 14, and the sequence stays contiguous across the 15→0 wrap.
5. Gappy input: sample_valid at 1/3 duty through FILL and POST. Required: replay equals the valid samples only, correctly windowed around the trigger.
6. Abort/reset mid-operation: abort at the 5th READ transfer. Required: dout_valid is low on the next cycle and busy=0. Re-arm then produces a correct full capture. Repeat using rst instead of abort.
